mem_access_unit: RTL

- Multi-cycle data-memory access unit downstream of the instruction decoder.
- Consumes MemWrite, the 2-bit memOp width code, the load-unsigned qualifier, the ALU-computed address and the store data.
- Runs one load/store transaction on a req/ack data bus with variable wait states.
- Returns aligned, sign- or zero-extended load data and stalls the core while busy.

---
 rtl/ctrl_pkg.sv | 30 +++
 rtl/mem_lane_align.sv | 44 ++++
 rtl/mem_access_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the memory access path: access widths, access-unit
// FSM states, fault causes, and the width/address alignment rule.
package ctrl_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  typedef enum logic {
    CAUSE_MISALIGN = 1'b0,
    CAUSE_TIMEOUT  = 1'b1
  } cause_t;

  // Width code 2'b11 is treated as a word access.
  function automatic logic is_aligned(input logic [1:0] op, input logic [1:0] addr_lo);
    case (op)
      MEM_BYTE: return 1'b1;
      MEM_HALF: return ~addr_lo[0];
      default:  return addr_lo == 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering for a 32-bit little-endian data bus: byte enables, store
// replication, and load lane extraction with sign/zero extension.
module mem_lane_align
  import ctrl_pkg::*;
(
  input  logic [1:0]  i_mem_op,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_load_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_bus_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata_rep,
  output logic [31:0] o_rdata_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;

  always_comb begin
    o_be        = 4'b1111;
    o_wdata_rep = i_wdata;
    o_rdata_ext = i_bus_rdata;
    w_byte      = i_bus_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half      = i_addr_lo[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    w_sign      = 1'b0;
    case (i_mem_op)
      MEM_BYTE: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_wdata_rep = {4{i_wdata[7:0]}};
        w_sign      = ~i_load_unsigned & w_byte[7];
        o_rdata_ext = {{24{w_sign}}, w_byte};
      end
      MEM_HALF: begin
        o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata_rep = {2{i_wdata[15:0]}};
        w_sign      = ~i_load_unsigned & w_half[15];
        o_rdata_ext = {{16{w_sign}}, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: one transaction at a time on a req/ack bus
// with a wait-state timeout, stalling the core while busy.
module mem_access_unit
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_write,
  input  logic [1:0]  mem_op,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic             r_uns;
  logic [1:0]       r_op;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  cause_t           r_cause;

  logic             w_accept;
  logic             w_aligned;
  logic             w_timeout;
  logic             w_in_bus;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata_rep;
  logic [31:0]      w_rdata_ext;

  assign w_accept  = (r_state == ST_IDLE) && req_valid;
  assign w_aligned = is_aligned(mem_op, addr[1:0]);
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_in_bus  = (r_state == ST_BUS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Ack wins over timeout when both land in the same BUS cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (req_valid) w_next_state = w_aligned ? ST_BUS : ST_FAULT;
      ST_BUS: begin
        if (bus_ack)        w_next_state = ST_DONE;
        else if (w_timeout) w_next_state = ST_FAULT;
      end
      ST_DONE:  w_next_state = ST_IDLE;
      ST_FAULT: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_op    <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cause <= CAUSE_MISALIGN;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_we    <= mem_write;
      r_uns   <= load_unsigned;
      r_op    <= mem_op;
      r_addr  <= addr;
      r_wdata <= wdata;
      r_cause <= CAUSE_MISALIGN;
    end else if (w_in_bus) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (bus_ack && !r_we)     r_rdata <= w_rdata_ext;
      if (!bus_ack && w_timeout) r_cause <= CAUSE_TIMEOUT;
    end
  end

  mem_lane_align u_lane (
    .i_mem_op        (r_op),
    .i_addr_lo       (r_addr[1:0]),
    .i_load_unsigned (r_uns),
    .i_wdata         (r_wdata),
    .i_bus_rdata     (bus_rdata),
    .o_be            (w_be),
    .o_wdata_rep     (w_wdata_rep),
    .o_rdata_ext     (w_rdata_ext)
  );

  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE) || (r_state == ST_FAULT);
  assign rdata_valid = (r_state == ST_DONE) && !r_we;
  assign rdata       = r_rdata;
  assign misalign    = (r_state == ST_FAULT) && (r_cause == CAUSE_MISALIGN);
  assign bus_err     = (r_state == ST_FAULT) && (r_cause == CAUSE_TIMEOUT);
  assign bus_req     = w_in_bus;
  assign bus_we      = w_in_bus && r_we;
  assign bus_addr    = w_in_bus ? {r_addr[31:2], 2'b00} : 32'h0;
  assign bus_be      = w_in_bus ? w_be : 4'h0;
  assign bus_wdata   = w_in_bus ? w_wdata_rep : 32'h0;

endmodule
